algo_run_ctrl: RTL and testbench
================================

Name: algo_run_ctrl

Overview:
- Run/sequencing controller in front of the sensor algorithm chain (background subtraction → stream width conversion → cluster locate).
- Gates 163-word sensor frames (3 header + 160 data) into the chain and issues a chain reset on every run start or background restart.
- Tracks the background-learning window and shadows the cluster configuration (threshold, size) so it changes only between frames.
- Sits between the frame source and the algorithm chain's Avalon-ST sink.

Parameters:
- BKG_FRAMES, 4, frames forwarded as background-learning frames after each chain reset; must match the chain's background depth.
- PKT_WORDS, 163, expected words per frame, including SOP and EOP words.
- ALGO_RST_CYCLES, 8, length in clk cycles of the algo_rst pulse.
- DEF_THRESHOLD, 16'd0, reset value of cfg_threshold.
- DEF_SIZE, 16'd1, reset value of cfg_size.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset (connects to rst_run).
- run_enable  in  1  level; 1 = acquisition run active.
- bkg_restart  in  1  single-cycle pulse; relearn background.
- cfg_threshold_in  in  16  register-map cluster threshold.
- cfg_size_in  in  16  register-map cluster size.
- in_data  in  32  frame source Avalon-ST data.
- in_ready  out  1  sink ready; ready latency 0.
- in_valid, in_startofpacket, in_endofpacket  in  1 each  sink framing.
- in_empty  in  2  sink empty.
- out_data  out  32  to algo chain.
- out_ready  in  1  from algo chain.
- out_valid, out_startofpacket, out_endofpacket  out  1 each  source framing.
- out_empty  out  2  source empty.
- algo_rst  out  1  synchronous reset to the algo chain.
- cfg_threshold, cfg_size  out  16 each  shadowed config to cluster_locate.
- bkg_phase  out  1  1 while learning frames are in flight.
- frame_count  out  32  frames forwarded since reset.
- drop_count  out  16  frames discarded; saturates at 0xFFFF.
- len_err  out  1  sticky; frame length ≠ PKT_WORDS.

Behaviour:
- A beat is transferred when in_valid and in_ready are both 1.
- Frame mode is decided on the SOP beat and held until the EOP beat transfers; pkt_active = 1 from SOP transfer through EOP transfer.
- FWD mode: in_ready = out_ready; out_valid = in_valid; data, empty, SOP and EOP pass through combinationally with zero latency.
- DROP mode: in_ready = 1, out_valid = 0.
- SOP beat with no frame active: FWD if state is LEARN or RUN, else DROP.
- A non-SOP beat while no frame is active is dropped and increments drop_count once per orphan run.
- State machine (2-bit state), reset → IDLE:
  - IDLE: algo_rst = 0. run_enable = 1 and pkt_active = 0 → ARST.
  - ARST: algo_rst = 1 for ALGO_RST_CYCLES cycles → LEARN with learn_cnt = 0.
  - LEARN: bkg_phase = 1. Each forwarded EOP increments learn_cnt; at the EOP that brings learn_cnt to BKG_FRAMES → RUN.
  - RUN: bkg_phase = 0.
  - From LEARN or RUN: run_enable = 0, or bkg_restart = 1, is latched as a pending request. It takes effect when pkt_active = 0, or on the cycle after the current frame's EOP transfers. run_enable = 0 → IDLE; otherwise → ARST.
  - bkg_restart in IDLE or ARST is ignored.
  - If run_enable = 0 and bkg_restart = 1 arrive in the same cycle, IDLE wins.
- Frames never truncate; DROP of an in-flight frame continues to its EOP.
- Config shadow: cfg_threshold and cfg_size load from the *_in inputs in any cycle with pkt_active = 0 and no SOP transfer. They are frozen for the whole frame.
- frame_count increments on each forwarded EOP transfer; wraps at 2^32.
- drop_count increments on each dropped SOP transfer.
- Length check: word counter (8 bits) resets on SOP. An EOP at count ≠ PKT_WORDS, or count exceeding PKT_WORDS, sets len_err. A frame is still closed on EOP.
- SOP arriving while pkt_active = 1 (missing EOP): sets len_err, closes the old frame, and decides the new frame.
- Reset values:
  - out_valid 0; algo_rst 0; bkg_phase 0; len_err 0.
  - frame_count 0; drop_count 0.
  - cfg_threshold DEF_THRESHOLD; cfg_size DEF_SIZE.
  - in_ready 1 (IDLE → DROP decision).
- Reset mid-frame: all state is cleared at once; the remainder of the frame is treated as orphan beats.

Test Plan:
- run_enable = 0, one 163-word frame → out_valid never 1; drop_count = 1; frame_count = 0.
- run_enable 0 → 1, then 6 frames, out_ready = 1 → algo_rst high exactly 8 cycles; bkg_phase = 1 for frames 1–4; frames 5–6 have bkg_phase = 0; frame_count = 6.
- In RUN, toggle out_ready 50% random → out_data sequence identical to input; in_ready equals out_ready every cycle; no beat lost or duplicated.
- bkg_restart at word 80 of a frame → frame completes forwarded; algo_rst asserts the cycle after EOP; next 4 frames have bkg_phase = 1.
- Change cfg_threshold_in from 100 to 200 at word 10 of a frame → cfg_threshold stays 100 until after EOP, then reads 200 before the next SOP.
- Frame with EOP at word 150 → len_err = 1; next SOP is decided normally; frame_count still increments.

Source files
------------

// File: rtl/algo_run_ctrl.sv
// Run/sequencing controller in front of the sensor algorithm chain.
// Gates frames, pulses the chain reset and shadows cluster config between frames.
module algo_run_ctrl #(
    parameter int unsigned BKG_FRAMES      = 4,
    parameter int unsigned PKT_WORDS       = 163,
    parameter int unsigned ALGO_RST_CYCLES = 8,
    parameter logic [15:0] DEF_THRESHOLD   = 16'd0,
    parameter logic [15:0] DEF_SIZE        = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_enable,
    input  logic        bkg_restart,
    input  logic [15:0] cfg_threshold_in,
    input  logic [15:0] cfg_size_in,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [1:0]  out_empty,
    output logic        algo_rst,
    output logic [15:0] cfg_threshold,
    output logic [15:0] cfg_size,
    output logic        bkg_phase,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic        len_err
);
    localparam int RW = $clog2(ALGO_RST_CYCLES + 1);
    localparam int LW = $clog2(BKG_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARST,
        S_LEARN,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_rst_cnt;
    logic [LW-1:0]   r_learn_cnt;
    logic            r_pend;
    logic            r_pkt_active;
    logic            r_mode_fwd;
    logic            r_orphan;
    logic [7:0]      r_wcnt;
    logic [15:0]     r_thr;
    logic [15:0]     r_size;
    logic [31:0]     r_frames;
    logic [15:0]     r_drops;
    logic            r_len_err;

    logic            w_live;
    logic            w_req;
    logic            w_sop_fwd;
    logic            w_fwd;
    logic            w_xfer;
    logic            w_sop_x;
    logic            w_in_frame;
    logic            w_fwd_eop;
    logic            w_close;
    logic            w_take;
    logic            w_orphan;
    logic            w_drop_inc;
    logic            w_len_bad;
    logic [8:0]      w_cnt_now;

    // A pending stop/restart also blocks new frames so none slip in before it lands.
    assign w_live    = (r_state == S_LEARN) || (r_state == S_RUN);
    assign w_req     = w_live & (r_pend | ~run_enable | bkg_restart);
    assign w_sop_fwd = w_live & ~w_req;
    assign w_fwd     = in_startofpacket ? w_sop_fwd
                                        : (r_pkt_active & r_mode_fwd);

    assign in_ready          = w_fwd ? out_ready : 1'b1;
    assign out_valid         = w_fwd & in_valid;
    assign out_data          = in_data;
    assign out_startofpacket = in_startofpacket;
    assign out_endofpacket   = in_endofpacket;
    assign out_empty         = in_empty;

    assign w_xfer     = in_valid & in_ready;
    assign w_sop_x    = w_xfer & in_startofpacket;
    assign w_in_frame = in_startofpacket | r_pkt_active;
    assign w_fwd_eop  = w_xfer & in_endofpacket & w_in_frame & w_fwd;
    assign w_close    = w_xfer & r_pkt_active
                      & (in_endofpacket | in_startofpacket);
    assign w_take     = w_req & (~r_pkt_active | w_close);
    assign w_orphan   = w_xfer & ~w_in_frame;
    assign w_drop_inc = (w_sop_x & ~w_sop_fwd) | (w_orphan & ~r_orphan);

    assign w_cnt_now = in_startofpacket ? 9'd1 : {1'b0, r_wcnt} + 9'd1;
    assign w_len_bad = w_xfer & w_in_frame
                     & ((in_endofpacket & (w_cnt_now != 9'(PKT_WORDS)))
                      | (w_cnt_now > 9'(PKT_WORDS))
                      | (in_startofpacket & r_pkt_active));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (run_enable && !r_pkt_active)
                    w_state_nxt = S_ARST;
            end
            S_ARST: begin
                if (!run_enable)
                    w_state_nxt = S_IDLE;
                else if (r_rst_cnt == RW'(ALGO_RST_CYCLES - 1))
                    w_state_nxt = S_LEARN;
            end
            S_LEARN: begin
                if (w_take)
                    w_state_nxt = run_enable ? S_ARST : S_IDLE;
                else if (w_fwd_eop
                         && r_learn_cnt == LW'(BKG_FRAMES - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_take)
                    w_state_nxt = run_enable ? S_ARST : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rst_cnt    <= '0;
            r_learn_cnt  <= '0;
            r_pend       <= 1'b0;
            r_pkt_active <= 1'b0;
            r_mode_fwd   <= 1'b0;
            r_orphan     <= 1'b0;
            r_wcnt       <= '0;
            r_thr        <= DEF_THRESHOLD;
            r_size       <= DEF_SIZE;
            r_frames     <= '0;
            r_drops      <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= (r_state == S_ARST) ? r_rst_cnt + 1'b1 : '0;

            if (r_state != S_LEARN)
                r_learn_cnt <= '0;
            else if (w_fwd_eop)
                r_learn_cnt <= r_learn_cnt + 1'b1;

            if (w_take || !w_live)
                r_pend <= 1'b0;
            else if (w_req)
                r_pend <= 1'b1;

            if (w_sop_x) begin
                r_pkt_active <= ~in_endofpacket;
                r_mode_fwd   <= w_sop_fwd;
            end else if (w_xfer && r_pkt_active && in_endofpacket) begin
                r_pkt_active <= 1'b0;
            end

            if (w_xfer && w_in_frame)
                r_wcnt <= w_cnt_now[8] ? 8'hFF : w_cnt_now[7:0];

            if (w_sop_x)
                r_orphan <= 1'b0;
            else if (w_orphan)
                r_orphan <= ~in_endofpacket;

            if (w_drop_inc && r_drops != 16'hFFFF)
                r_drops <= r_drops + 16'd1;

            if (w_fwd_eop)
                r_frames <= r_frames + 32'd1;

            if (w_len_bad)
                r_len_err <= 1'b1;

            if (!r_pkt_active && !w_sop_x) begin
                r_thr  <= cfg_threshold_in;
                r_size <= cfg_size_in;
            end
        end
    end

    assign algo_rst      = (r_state == S_ARST);
    assign bkg_phase     = (r_state == S_LEARN);
    assign cfg_threshold = r_thr;
    assign cfg_size      = r_size;
    assign frame_count   = r_frames;
    assign drop_count    = r_drops;
    assign len_err       = r_len_err;
endmodule

// File: tb/tb_algo_run_ctrl.sv
// Bench for algo_run_ctrl: random frames and ready, frame-level model,
// scoreboard queue drained by an output monitor.
module tb_algo_run_ctrl;
    localparam int BKG = 4;
    localparam int PKT = 163;
    localparam int ARC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_enable = 1'b0;
    logic        bkg_restart = 1'b0;
    logic [15:0] cfg_threshold_in = 16'd7;
    logic [15:0] cfg_size_in = 16'd5;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [1:0]  in_empty = 2'd0;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        algo_rst;
    logic [15:0] cfg_threshold;
    logic [15:0] cfg_size;
    logic        bkg_phase;
    logic [31:0] frame_count;
    logic [15:0] drop_count;
    logic        len_err;

    algo_run_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .run_enable        (run_enable),
        .bkg_restart       (bkg_restart),
        .cfg_threshold_in  (cfg_threshold_in),
        .cfg_size_in       (cfg_size_in),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
        .algo_rst          (algo_rst),
        .cfg_threshold     (cfg_threshold),
        .cfg_size          (cfg_size),
        .bkg_phase         (bkg_phase),
        .frame_count       (frame_count),
        .drop_count        (drop_count),
        .len_err           (len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } beat_t;

    beat_t       sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          rand_rdy = 1'b0;
    bit          chk_ready = 1'b0;
    int          restart_word = -1;
    int          cfg_word = -1;
    logic [15:0] cfg_new = '0;
    logic [15:0] cfg_old = '0;

    // Frame-level model of what the controller should do.
    bit          m_live = 1'b0;
    int          m_learn_left = 0;
    int unsigned m_frames = 0;
    int          m_drops = 0;
    bit          m_len_err = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n);
        bit    fwd;
        bit    bkg;
        bit    rdy;
        beat_t b;
        fwd = m_live;
        bkg = (m_learn_left > 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0)
                cyc($urandom_range(1, 2));
            in_data  = $urandom;
            in_sop   = (i == 0);
            in_eop   = (i == n - 1);
            in_valid = 1'b1;
            if (i == restart_word)
                bkg_restart = 1'b1;
            if (i == cfg_word)
                cfg_threshold_in = cfg_new;
            if (fwd) begin
                b.d = in_data;
                b.s = in_sop;
                b.e = in_eop;
                sb.push_back(b);
            end
            rdy = 1'b0;
            for (int c = 0; c < 200 && !rdy; c++) begin
                @(negedge clk);
                rdy = in_ready;
                if (fwd && chk_ready)
                    check("in_ready_eq_out_ready", in_ready, out_ready);
                if (rdy && i == 0 && fwd)
                    check("bkg_phase_at_sop", bkg_phase, bkg);
                if (rdy && i == n - 1 && cfg_word >= 0)
                    check("cfg_frozen_at_eop", cfg_threshold, cfg_old);
                @(posedge clk);
                #1;
                bkg_restart = 1'b0;
            end
            if (!rdy)
                check("beat_timeout", rdy, 1);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        if (fwd) begin
            m_frames++;
            if (m_learn_left > 0)
                m_learn_left--;
        end else begin
            m_drops++;
        end
        if (n != PKT)
            m_len_err = 1'b1;
        if (fwd && restart_word >= 0)
            m_learn_left = BKG;
    endtask

    task automatic arst_width(output int w);
        bit seen;
        seen = 1'b0;
        w = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (algo_rst) begin
                w++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out_unexpected: got beat %0h, none expected",
                         out_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("out_beat", {out_data, out_sop, out_eop},
                      {e.d, e.s, e.e});
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_algo_rst", algo_rst, 0);
        check("rst_bkg_phase", bkg_phase, 0);
        check("rst_len_err", len_err, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_cfg_threshold", cfg_threshold, 16'd0);
        check("rst_cfg_size", cfg_size, 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);
        check("cfg_size_load", cfg_size, 16'd5);
        check("cfg_thr_load", cfg_threshold, 16'd7);

        send_frame(PKT);
        cyc(2);
        check("idle_drop_count", drop_count, 32'(m_drops));
        check("idle_frame_count", frame_count, m_frames);

        run_enable = 1'b1;
        arst_width(w);
        check("algo_rst_width_start", w, ARC);
        m_live = 1'b1;
        m_learn_left = BKG;
        repeat (6) send_frame(PKT);
        check("frames_after_learn", frame_count, m_frames);
        check("bkg_phase_in_run", bkg_phase, 0);

        rand_rdy = 1'b1;
        chk_ready = 1'b1;
        repeat (3) send_frame(PKT);

        restart_word = 80;
        send_frame(PKT);
        restart_word = -1;
        check("algo_rst_after_eop", algo_rst, 1);
        arst_width(w);
        check("algo_rst_width_restart", w, ARC);
        repeat (5) send_frame(PKT);

        cfg_threshold_in = 16'd100;
        cyc(2);
        check("cfg_thr_100", cfg_threshold, 16'd100);
        cfg_old  = 16'd100;
        cfg_new  = 16'd200;
        cfg_word = 10;
        send_frame(PKT);
        cfg_word = -1;
        check("cfg_hold_after_eop", cfg_threshold, 16'd100);
        cyc(1);
        check("cfg_update_before_sop", cfg_threshold, 16'd200);

        check("len_err_before_short", len_err, m_len_err);
        send_frame(150);
        cyc(1);
        check("len_err_short", len_err, m_len_err);
        send_frame(PKT);
        cyc(2);
        check("final_frame_count", frame_count, m_frames);
        check("final_drop_count", drop_count, 32'(m_drops));
        check("final_len_err", len_err, m_len_err);
        check("scoreboard_empty", sb.size(), 0);
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
